// File: rtl/debug_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : debug_uart_rx
// Brief    : 8N1 serial receiver with first-word fall-through byte FIFO,
//            sticky overrun/frame-error flags and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module debug_uart_rx #(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  input  logic                          rx_pop,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          irq
);

  localparam int c_CPB  = CLK_HZ / BIT_RATE;
  localparam int c_HALF = c_CPB / 2;
  localparam int c_CW   = (c_CPB > 1) ? $clog2(c_CPB) : 1;
  localparam int c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_NW   = c_AW + 1;

  localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(c_HALF - 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_CPB - 1);
  localparam logic [c_NW-1:0] c_FULL     = c_NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic            sync1_q, sync2_q;
  logic            line;
  state_t          state_q;
  logic [c_CW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic            frame_err_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_NW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            pop_ok, push_ok;

  // Synchroniser resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!line) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == c_CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= line ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + c_CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= line;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + c_CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_q <= '0;
            if (line) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + c_CW'(1);
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (line) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A pop frees the head slot first, so a push into a full FIFO can still land.
  always_comb begin
    pop_ok    = rx_pop && (count_q != '0);
    push_ok   = push_q && ((count_q != c_FULL) || pop_ok);
    wr_ptr_d  = push_ok ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok  ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
    count_d   = count_q + c_NW'(push_ok) - c_NW'(pop_ok);
    overrun_d = err_clr ? 1'b0 : overrun_q;
    if (push_q && !push_ok) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_valid  = (count_q != '0);
  assign rx_count  = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign irq       = rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_uart_rx
// Brief    : Self-checking bench for debug_uart_rx (CPB=16, HALF=8, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       rx_pop;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       irq;

  debug_uart_rx #(
    .CLK_HZ    (16),
    .BIT_RATE  (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rx_pop   (rx_pop),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_count (rx_count),
    .overrun  (overrun),
    .frame_err(frame_err),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic       exp_ovr;
    logic [7:0] exp_head;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         rise_k;
  vec_t       tbl[5];
  logic [7:0] q[$];
  logic       m_ovr;
  logic       m_ferr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pin fall happens at k=0; outputs seen at step k reflect k rising edges since then.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_k);
    logic [2:0] c0;
    c0     = rx_count;
    rise_k = -1;
    for (int k = 0; k < 160; k++) begin
      int b;
      b = k / 16;
      if (rise_k < 0 && rx_count != c0) rise_k = k;
      uart_rxd = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      rx_pop   = (k == pop_k);
      @(negedge clk);
    end
    rx_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  rx_data,   32'h0);
    chk({tag, "_valid"}, rx_valid,  32'h0);
    chk({tag, "_count"}, rx_count,  32'h0);
    chk({tag, "_ovr"},   overrun,   32'h0);
    chk({tag, "_ferr"},  frame_err, 32'h0);
    chk({tag, "_irq"},   irq,       32'h0);
  endtask

  initial begin
    tbl[0] = '{data: 8'h01, stop: 1'b1, exp_count: 1, exp_ovr: 1'b0, exp_head: 8'h01};
    tbl[1] = '{data: 8'h02, stop: 1'b1, exp_count: 2, exp_ovr: 1'b0, exp_head: 8'h01};
    tbl[2] = '{data: 8'h03, stop: 1'b1, exp_count: 3, exp_ovr: 1'b0, exp_head: 8'h01};
    tbl[3] = '{data: 8'h04, stop: 1'b1, exp_count: 4, exp_ovr: 1'b0, exp_head: 8'h01};
    tbl[4] = '{data: 8'h05, stop: 1'b1, exp_count: 4, exp_ovr: 1'b1, exp_head: 8'h01};

    rst = 1'b1; uart_rxd = 1'b1; rx_pop = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(4);

    // Single frame latency and pop
    send_frame(8'hA5, 1'b1, -1);
    chk("t1_rise_cycle", rise_k, 32'd156);
    chk("t1_data",  rx_data,  32'hA5);
    chk("t1_count", rx_count, 32'd1);
    chk("t1_irq",   irq,      32'd1);
    pop();
    chk("t1_valid_after_pop", rx_valid, 32'd0);
    chk("t1_data_after_pop",  rx_data,  32'h00);
    idle(4);

    // Short glitch is a false start
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("t2_glitch_count", rx_count, 32'd0);
    send_frame(8'h3C, 1'b1, -1);
    idle(4);
    chk("t2_data",  rx_data,  32'h3C);
    chk("t2_count", rx_count, 32'd1);
    pop();
    idle(4);

    // Back-to-back frames into a full FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, -1);
      chk($sformatf("t3_count_%0d", i), rx_count, tbl[i].exp_count);
      chk($sformatf("t3_ovr_%0d", i),   overrun,  tbl[i].exp_ovr);
      chk($sformatf("t3_head_%0d", i),  rx_data,  tbl[i].exp_head);
    end
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_pop_%0d", i), rx_data, 32'(i + 1));
      pop();
    end
    chk("t3_empty", rx_valid, 32'd0);
    clear_errs();
    chk("t3_ovr_clr", overrun, 32'd0);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, -1);
    repeat (40) @(negedge clk);
    chk("t4_ferr",  frame_err, 32'd1);
    chk("t4_count", rx_count,  32'd0);
    idle(8);
    send_frame(8'h7E, 1'b1, -1);
    idle(4);
    chk("t4_data",       rx_data,   32'h7E);
    chk("t4_count_7e",   rx_count,  32'd1);
    chk("t4_ferr_stays", frame_err, 32'd1);
    pop();

    // Pop in the push cycle of a full FIFO
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    send_frame(8'h33, 1'b1, -1);
    send_frame(8'h44, 1'b1, -1);
    send_frame(8'h99, 1'b1, 155);
    idle(4);
    chk("t5_ovr",   overrun,  32'd0);
    chk("t5_count", rx_count, 32'd4);
    chk("t5_h0", rx_data, 32'h22); pop();
    chk("t5_h1", rx_data, 32'h33); pop();
    chk("t5_h2", rx_data, 32'h44); pop();
    chk("t5_h3", rx_data, 32'h99); pop();

    // Reset mid-frame with stored data and a sticky flag present
    send_frame(8'h5A, 1'b1, -1);
    uart_rxd = 1'b0; repeat (16) @(negedge clk);
    uart_rxd = 1'b1; repeat (16) @(negedge clk);
    uart_rxd = 1'b0; repeat (16) @(negedge clk);
    uart_rxd = 1'b1; repeat (16) @(negedge clk);
    rst = 1'b1; uart_rxd = 1'b0;
    @(negedge clk);
    rst = 1'b0; uart_rxd = 1'b1;
    chk_all_zero("t6_rst");
    idle(20);
    chk("t6_no_spurious", rx_count, 32'd0);
    send_frame(8'h55, 1'b1, -1);
    idle(4);
    chk("t6_data",  rx_data,  32'h55);
    chk("t6_count", rx_count, 32'd1);
    pop();

    // Randomised traffic against a queue model
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      int         npop;
      logic [7:0] d;
      logic       st;
      logic [7:0] exp_head;
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop();
        if (q.size() > 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_errs();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, st, -1);
      if (!st)              m_ferr = 1'b1;
      else if (q.size() < 4) q.push_back(d);
      else                   m_ovr = 1'b1;
      idle(6);
      exp_head = (q.size() > 0) ? q[0] : 8'h00;
      chk($sformatf("rnd_count_%0d", n), rx_count,  q.size());
      chk($sformatf("rnd_head_%0d", n),  rx_data,   exp_head);
      chk($sformatf("rnd_ovr_%0d", n),   overrun,   m_ovr);
      chk($sformatf("rnd_ferr_%0d", n),  frame_err, m_ferr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_uart_rx.md
Name: debug_uart_rx

Overview:
- Receive-side companion to the debug UART transmitter: deserialises 8N1 frames from the board UART RX pin into a small FIFO.
- Exposes a byte/status interface that the top-level peripheral read mux maps into the debug UART address slots, plus an interrupt line.
- Fixed bit rate, no oversampling: mid-bit sampling timed from the start-bit falling edge.

Parameters:
- CLK_HZ, 27_000_000, system clock frequency in Hz.
- BIT_RATE, 9600, serial bit rate. CPB = CLK_HZ/BIT_RATE (integer division); HALF = CPB/2.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input; idle high.
- rx_pop  in  1  1-cycle pulse: discard head byte (CPU read of data register completed).
- err_clr  in  1  1-cycle pulse: clear sticky error flags.
- rx_data  out  8  FIFO head byte (first-word fall-through); 0x00 when empty.
- rx_valid  out  1  FIFO non-empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  bytes held.
- overrun  out  1  sticky: a received byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: a stop bit sampled low.
- irq  out  1  equals rx_valid (level interrupt).

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - Outputs rx_data, rx_valid, rx_count, overrun, frame_err and irq are all 0.
  - Internally, FIFO pointers are cleared, the FSM is in IDLE, and both synchroniser flops are 1.
- uart_rxd passes through a 2-flop synchroniser; "line" below means the synchronised value.
- One baud counter, width enough for CPB-1, cleared on every state entry.
- FSM:
  - IDLE: when line==0, enter START.
  - START: when counter reaches HALF-1, sample the line.
    - If 1, this is a false start: return to IDLE.
    - If 0, enter DATA with bit index 0.
  - DATA: every CPB cycles, sample the line into shift bit[index], LSB first.
    - After the 8th bit, enter STOP.
  - STOP: after CPB cycles, sample the line.
    - If 1, issue the push and go to IDLE.
    - If 0, set frame_err, discard the byte and enter BREAK.
  - BREAK: wait for line==1, then go to IDLE. A held-low line never creates frames.
- Sample points, counted from the first cycle line==0:
  - Start bit: HALF cycles.
  - Data bit i: HALF+(i+1)·CPB cycles.
  - Stop bit: HALF+9·CPB cycles.
- Push timing: the push is registered in the cycle after the stop sample, so rx_valid rises the following cycle.
- FIFO push when full: the byte is dropped, overrun is set and the contents are unchanged.
- Simultaneous push and pop when full: the pop is applied first, the push succeeds, there is no overrun, and rx_count is unchanged.
- Pop when empty: ignored; the count never underflows.
- Pointers wrap modulo FIFO_DEPTH. rx_count is 0..FIFO_DEPTH.
- Sticky flags: err_clr clears them. If err_clr coincides with a new error event, the set wins.
- rst asserted mid-frame: abandons the frame immediately and clears FIFO and flags. Line activity during reset is ignored.

Test Plan:
All tests use CLK_HZ=16, BIT_RATE=1 (CPB=16, HALF=8).
1. Drive a 0xA5 frame, then idle → rx_valid=1 exactly 2+8+9·16+2 cycles after the pin fall, with rx_data=0xA5, rx_count=1, irq=1. Pulse rx_pop → rx_valid=0, rx_data=0x00.
2. Pulse the pin low for 4 cycles → no push, FSM back in IDLE. A following 0x3C frame is received correctly.
3. Send 0x01..0x05 back-to-back with no pops → rx_count=4, overrun=1. Four pops return 01,02,03,04, then rx_valid=0. err_clr → overrun=0.
4. Send a 0x3C frame with stop bit 0, then hold low 40 cycles → frame_err=1, rx_count=0, no further frames. Release high, send 0x7E → 0x7E received, frame_err stays 1.
5. Fill the FIFO with 4 bytes; send 0x99 and assert rx_pop in the push cycle → overrun=0, rx_count=4, the last entry is 0x99.
6. Assert rst for 1 cycle after 3 data bits of a frame → all outputs 0. A subsequent 0x55 frame is received correctly.
